// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter: write-back arbiter behind the functional units.
// Every FU finish pulse is latched into a per-FU holding slot. A round-robin
// arbiter commits one slot per cycle to the register-file write port and
// returns a one-hot done pulse to the scoreboard.
// Optional build macro FU_WB_BYPASS_EN: a finish into an empty slot competes
// in the same cycle's arbitration. If it wins, it is written with zero latency
// and is not latched.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   fu_finish/res/rd    per-FU completion pulse, 32-bit result, dest register
//   fu_hold             slot occupied (registered)
//   wb_en/addr/data     register-file write port
//   wb_done             one-hot commit indicator
//   wb_overflow         sticky: a finish overwrote an occupied, ungranted slot
module fu_wb_arbiter #(
    parameter int unsigned NUM_FU = 5,
    parameter int unsigned RD_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_FU-1:0]        fu_finish,
    input  logic [NUM_FU*32-1:0]     fu_res,
    input  logic [NUM_FU*RD_W-1:0]   fu_rd,
    output logic [NUM_FU-1:0]        fu_hold,
    output logic                     wb_en,
    output logic [RD_W-1:0]          wb_addr,
    output logic [31:0]              wb_data,
    output logic [NUM_FU-1:0]        wb_done,
    output logic                     wb_overflow
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] valid_q, valid_d;
    logic [RD_W-1:0]   rd_q   [NUM_FU];
    logic [RD_W-1:0]   rd_d   [NUM_FU];
    logic [DATA_W-1:0] data_q [NUM_FU];
    logic [DATA_W-1:0] data_d [NUM_FU];
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              overflow_q, overflow_d;

    logic [NUM_FU-1:0] cand;
    logic [NUM_FU-1:0] gnt_vec;
    logic [NUM_FU-1:0] load_vec;
    logic [PTR_W-1:0]  scan_idx;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_found;
    logic [RD_W-1:0]   gnt_rd;
    logic [DATA_W-1:0] gnt_data;

    // Round-robin search starting at rr_ptr_q, wrapping NUM_FU-1 -> 0
    always_comb begin
        cand = valid_q;
`ifdef FU_WB_BYPASS_EN
        cand = valid_q | fu_finish;
`endif
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        gnt_vec   = '0;
        for (int k = 0; k < int'(NUM_FU); k++) begin
            scan_idx = PTR_W'((32'(rr_ptr_q) + 32'(k)) % NUM_FU);
            if (!gnt_found && cand[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
        if (gnt_found) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    // Write-port mux from the granted slot (or the bypassed FU input)
    always_comb begin
        gnt_rd   = rd_q[gnt_idx];
        gnt_data = data_q[gnt_idx];
`ifdef FU_WB_BYPASS_EN
        if (!valid_q[gnt_idx]) begin
            gnt_rd   = fu_rd[32'(gnt_idx)*RD_W +: RD_W];
            gnt_data = fu_res[32'(gnt_idx)*DATA_W +: DATA_W];
        end
`endif
        wb_done = gnt_vec;
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        if (gnt_found) begin
            wb_en   = (gnt_rd != '0);
            wb_addr = gnt_rd;
            wb_data = gnt_data;
        end
    end

    // Slot update: commit clears, finish loads; a load into an occupied,
    // ungranted slot sets the sticky overflow flag
    always_comb begin
        valid_d    = valid_q;
        rd_d       = rd_q;
        data_d     = data_q;
        rr_ptr_d   = rr_ptr_q;
        overflow_d = overflow_q;
        load_vec   = fu_finish;
`ifdef FU_WB_BYPASS_EN
        // a bypassed result has already been written and is not latched
        load_vec = fu_finish & ~(gnt_vec & ~valid_q);
`endif
        if (gnt_found) begin
            rr_ptr_d = (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
        for (int i = 0; i < int'(NUM_FU); i++) begin
            if (gnt_vec[i]) begin
                valid_d[i] = 1'b0;
            end
            if (load_vec[i]) begin
                valid_d[i] = 1'b1;
                rd_d[i]    = fu_rd[i*RD_W +: RD_W];
                data_d[i]  = fu_res[i*DATA_W +: DATA_W];
                if (valid_q[i] && !gnt_vec[i]) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(NUM_FU); i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
        end
    end

    assign fu_hold     = valid_q;
    assign wb_overflow = overflow_q;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Testbench for fu_wb_arbiter: directed scenarios plus randomized finish
// traffic, all compared against a slot/queue-level reference model.
module tb_fu_wb_arbiter;

    localparam int N  = 5;
    localparam int RW = 5;
`ifdef FU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [N-1:0]    fu_finish;
    logic [N*32-1:0] fu_res;
    logic [N*RW-1:0] fu_rd;
    logic [N-1:0]    fu_hold;
    logic            wb_en;
    logic [RW-1:0]   wb_addr;
    logic [31:0]     wb_data;
    logic [N-1:0]    wb_done;
    logic            wb_overflow;

    fu_wb_arbiter #(.NUM_FU(N), .RD_W(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fu_finish  (fu_finish),
        .fu_res     (fu_res),
        .fu_rd      (fu_rd),
        .fu_hold    (fu_hold),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_done    (wb_done),
        .wb_overflow(wb_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // stimulus staging for the next cycle
    logic [N-1:0]    r_fin;
    logic [N*32-1:0] r_res;
    logic [N*RW-1:0] r_rd;

    // reference model: pending results per FU and the rotating start point
    bit          m_valid [N];
    logic [4:0]  m_rd    [N];
    logic [31:0] m_data  [N];
    int          m_rr;
    bit          m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_rd[i]    = '0;
            m_data[i]  = '0;
        end
        m_rr  = 0;
        m_ovf = 1'b0;
    endtask

    task automatic clear_in();
        r_fin = '0;
        r_res = '0;
        r_rd  = '0;
    endtask

    task automatic set_fu(input int i, input logic [31:0] res, input logic [4:0] rd);
        r_fin[i]          = 1'b1;
        r_res[i*32 +: 32] = res;
        r_rd[i*RW +: RW]  = rd;
    endtask

    // One clock cycle: apply inputs, check outputs against model, advance model
    task automatic tick(input logic r);
        int          g;
        int          idx;
        logic [31:0] e_done;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_hold;
        bit          v0 [N];
        rst       = r;
        fu_finish = r_fin;
        fu_res    = r_res;
        fu_rd     = r_rd;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (g < 0 && (m_valid[idx] || (BYP && r_fin[idx]))) g = idx;
        end
        e_done = '0;
        e_addr = '0;
        e_data = '0;
        if (g >= 0) begin
            e_done[g] = 1'b1;
            if (m_valid[g]) begin
                e_addr = m_rd[g];
                e_data = m_data[g];
            end else begin
                e_addr = r_rd[g*RW +: RW];
                e_data = r_res[g*32 +: 32];
            end
        end
        e_hold = '0;
        for (int i = 0; i < N; i++) e_hold[i] = m_valid[i];
        chk("wb_done", 32'(wb_done), e_done);
        chk("wb_en", 32'(wb_en), 32'((g >= 0) && (e_addr != 5'd0)));
        chk("wb_addr", 32'(wb_addr), 32'(e_addr));
        chk("wb_data", wb_data, e_data);
        chk("fu_hold", 32'(fu_hold), e_hold);
        chk("wb_overflow", 32'(wb_overflow), 32'(m_ovf));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) v0[i] = m_valid[i];
            if (g >= 0) begin
                m_valid[g] = 1'b0;
                m_rr       = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (r_fin[i] && !(BYP && g == i && !v0[i])) begin
                    if (v0[i] && g != i) m_ovf = 1'b1;
                    m_valid[i] = 1'b1;
                    m_rd[i]    = r_rd[i*RW +: RW];
                    m_data[i]  = r_res[i*32 +: 32];
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        fu_finish = '0;
        fu_res    = '0;
        fu_rd     = '0;
        clear_in();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state and idle
        chk("rst_hold", 32'(fu_hold), 32'd0);
        chk("rst_en", 32'(wb_en), 32'd0);
        repeat (5) tick(1'b0);

        // single finish on FU1
        set_fu(1, 32'h0000_0042, 5'd7);
        tick(1'b0);
        clear_in();
`ifndef FU_WB_BYPASS_EN
        chk("single_en", 32'(wb_en), 32'd1);
        chk("single_addr", 32'(wb_addr), 32'd7);
        chk("single_data", wb_data, 32'h42);
        chk("single_done", 32'(wb_done), 32'b00010);
        chk("single_hold_k1", 32'(fu_hold[1]), 32'd1);
`endif
        tick(1'b0);
        chk("single_hold_k2", 32'(fu_hold[1]), 32'd0);

        // five simultaneous finishes from rr_ptr=0
        tick(1'b1);
        for (int i = 0; i < N; i++) set_fu(i, 32'hA0 + 32'(i), 5'(i + 1));
        tick(1'b0);
        clear_in();
        for (int j = 0; j < N; j++) begin
`ifndef FU_WB_BYPASS_EN
            chk("five_done", 32'(wb_done), 32'(1) << j);
            chk("five_data", wb_data, 32'hA0 + 32'(j));
            chk("five_addr", 32'(wb_addr), 32'(j + 1));
`endif
            tick(1'b0);
        end

        // wrap: FU2 commit moves rr_ptr to 3, then slots 0 and 4 pending
        set_fu(2, 32'hB2, 5'd9);
        tick(1'b0);
        clear_in();
        set_fu(0, 32'hB0, 5'd10);
        set_fu(4, 32'hB4, 5'd11);
        tick(1'b0);
        clear_in();
`ifndef FU_WB_BYPASS_EN
        chk("wrap_first_done", 32'(wb_done), 32'b10000);
        chk("wrap_first_data", wb_data, 32'hB4);
`endif
        tick(1'b0);
`ifndef FU_WB_BYPASS_EN
        chk("wrap_second_done", 32'(wb_done), 32'b00001);
        chk("wrap_second_data", wb_data, 32'hB0);
`endif
        tick(1'b0);

        // rd == 0 consumes the slot without a write
        set_fu(2, 32'hDEAD, 5'd0);
        tick(1'b0);
        clear_in();
`ifndef FU_WB_BYPASS_EN
        chk("rd0_done", 32'(wb_done), 32'b00100);
        chk("rd0_en", 32'(wb_en), 32'd0);
`endif
        tick(1'b0);

        // overflow: slot 0 waits behind 3 and 4 and is overwritten
        set_fu(3, 32'hC3, 5'd3);
        set_fu(4, 32'hC4, 5'd4);
        tick(1'b0);
        clear_in();
        set_fu(0, 32'h1, 5'd12);
        tick(1'b0);
        clear_in();
        set_fu(0, 32'h2, 5'd12);
        tick(1'b0);
        clear_in();
        chk("ovf_flag", 32'(wb_overflow), 32'd1);
        chk("ovf_done", 32'(wb_done), 32'b00001);
        chk("ovf_data", wb_data, 32'h2);
        set_fu(1, 32'h77, 5'd5);
        tick(1'b1);
        clear_in();
        chk("ovf_rst_flag", 32'(wb_overflow), 32'd0);
        chk("ovf_rst_hold", 32'(fu_hold), 32'd0);
        chk("ovf_rst_en", 32'(wb_en), 32'd0);
        chk("ovf_rst_done", 32'(wb_done), 32'd0);
        tick(1'b0);

        // randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            clear_in();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) < 3) set_fu(i, $urandom, 5'($urandom_range(0, 31)));
            end
            tick($urandom_range(0, 63) == 0);
        end
        clear_in();
        repeat (N + 1) tick(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
- Write-back stage downstream of the functional units (ALU, mul, div, mem, jump).
- Each FU raises a one-cycle `finish` pulse with its 32-bit result. This block latches every result into a per-FU holding slot.
- Round-robin arbitration commits one result per cycle to the register-file write port.
- Releases the FU to the scoreboard via a one-hot done pulse.

Parameters:
- NUM_FU, 5, number of functional-unit sources (index 0..NUM_FU-1).
- RD_W, 5, destination register address width.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- fu_finish  input  NUM_FU  per-FU one-cycle completion pulse.
- fu_res  input  NUM_FU*32  packed results; FU i occupies bits [32*i+31:32*i].
- fu_rd  input  NUM_FU*RD_W  packed destination register per FU, valid with fu_finish.
- fu_hold  output  NUM_FU  slot i occupied; scoreboard must not issue to FU i.
- wb_en  output  1  register-file write enable.
- wb_addr  output  RD_W  register-file write address.
- wb_data  output  32  register-file write data.
- wb_done  output  NUM_FU  one-hot: FU i's result was committed this cycle.
- wb_overflow  output  1  sticky error: a finish arrived for a slot that was still occupied.

Behaviour:
- State:
  - per-FU slot {valid, rd, data}.
  - rr_ptr, log2(NUM_FU) bits.
  - overflow flag.
- Reset (rst=1 at posedge):
  - all slot valid=0; rr_ptr=0; overflow=0.
  - outputs then: fu_hold=0, wb_en=0, wb_done=0, wb_addr=0, wb_data=0, wb_overflow=0.
  - Reset mid-operation discards all pending results; finish pulses sampled in the reset cycle are dropped.
- Capture:
  - fu_finish[i]=1 at posedge loads slot i with fu_res/fu_rd and sets valid=1.
- Arbitration (combinational on slot valid bits):
  - Search starts at rr_ptr, ascending with wrap NUM_FU-1 -> 0.
  - First valid slot g is granted.
  - No valid slot: no grant; wb_done=0, wb_en=0, wb_addr=0, wb_data=0.
- Commit for grant g:
  - wb_done[g]=1; wb_addr=slot rd; wb_data=slot data.
  - wb_en=1 only if rd!=0; rd==0 still consumes the slot and pulses wb_done.
  - At posedge: slot g valid<=0; rr_ptr<=(g+1) mod NUM_FU.
  - rr_ptr is unchanged when there is no grant.
- Latency: finish sampled at edge k -> earliest commit in cycle k+1, i.e. one-cycle latency.
- Throughput: one commit per cycle.
  - Worst case for a pending slot is NUM_FU-1 cycles of wait.
  - Fairness: every valid slot commits within NUM_FU cycles.
- fu_hold[i] = slot i valid (registered, no combinational path from fu_finish).
- Simultaneous events:
  - Slot i granted and fu_finish[i]=1 in the same cycle: old value commits; new value loads; valid stays 1; no overflow.
  - Slot i valid, not granted, and fu_finish[i]=1: new value overwrites the slot; overflow<=1 (sticky until rst).
  - Multiple finishes in one cycle: all captured; commits are serialized by round-robin.
- The output mux is combinational from registered slot state; wb_* are stable for the whole cycle.

Optional Feature:
- Macro: FU_WB_BYPASS_EN.
- Defined:
  - fu_finish[i] with slot i empty takes part in the same-cycle arbitration as a virtual valid slot.
  - If it is granted, its result is written in that cycle (zero latency) and it is not latched.
  - If it is not granted, it is latched as normal.
  - Priority order is unchanged (rr_ptr search over the combined valid vector).
- Undefined: strictly one-cycle latency as described above; no combinational path from fu_* inputs to wb_*.

Test Plan:
- Reset then idle 5 cycles -> wb_en=0, wb_done=0, fu_hold=0, wb_overflow=0 throughout.
- Single finish: fu_finish[1]=1, fu_res[1]=32'h0000_0042, fu_rd[1]=5'd7 at edge k.
  - Without the macro: cycle k+1 has wb_en=1, wb_addr=7, wb_data=0x42, wb_done=5'b00010.
  - fu_hold[1]=1 during k+1 and 0 at k+2.
- Five simultaneous finishes: all FUs, rd=1..5, data=0xA0..0xA4, rr_ptr=0 -> commits in order FU0..FU4 on five consecutive cycles; rr_ptr ends at 0.
- Round-robin wrap: rr_ptr=3, slots 0 and 4 valid -> FU4 commits first, then FU0; rr_ptr ends at 1.
- rd=0: fu_finish[2] with rd=0, data=0xDEAD -> wb_done[2]=1, wb_en=0 in the commit cycle.
- Overflow and reset: slot 0 held (higher-priority slots kept busy) and a second fu_finish[0] with data 0x2 -> wb_overflow=1 and a later commit carries 0x2; asserting rst -> wb_overflow=0, all fu_hold=0, no commit follows.
